// File: rtl/tv_sync_pkg.sv
// tv_sync_pkg: shared TV sync timing constants and FSM state type.
// Used by tv_sync_gen and the trigger receivers.
package tv_sync_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ODD,
    EVEN
  } state_t;

  localparam logic MODE_PAL  = 1'b0;
  localparam logic MODE_NTSC = 1'b1;

  localparam int PAL_CLKS   = 640;
  localparam int NTSC_CLKS  = 635;
  localparam int PAL_TOTAL  = 625;
  localparam int NTSC_TOTAL = 525;
  localparam int HS_W_DEF   = 47;
  localparam int VS_N_DEF   = 3;

  function automatic int odd_lines(input int total);
    return (total + 1) / 2;
  endfunction

  localparam int PAL_ODD  = odd_lines(PAL_TOTAL);
  localparam int NTSC_ODD = odd_lines(NTSC_TOTAL);

endpackage

// File: rtl/tv_line_timer.sv
// tv_line_timer: pixel counter, hs pulse and line-wrap strobe.
// TV_SYNC_EQ_PULSE_EN adds equalising pulses on VS lines.
module tv_line_timer
  import tv_sync_pkg::*;
#(
  parameter int HS_WIDTH = HS_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       start,
  input  logic [9:0] cur_clks,
  input  logic [9:0] nxt_clks,
  input  logic       eq_line,
  output logic       hs_out,
  output logic       line_wrap
);

  localparam logic [9:0] HS_W = 10'(HS_WIDTH);

  logic [9:0] pix;
  logic [9:0] pix_n;
  logic       hs_n;

  assign line_wrap = run && !start &&
                     (pix == cur_clks - 10'd1);

`ifdef TV_SYNC_EQ_PULSE_EN
  localparam logic [9:0] EQ_W = 10'(HS_WIDTH / 2);

  logic [9:0] half;
  assign half = nxt_clks >> 1;
`else
  logic unused_eq;
  assign unused_eq = ^{eq_line, nxt_clks};
`endif

  always_comb begin
    pix_n = pix + 10'd1;
    if (!run || start || line_wrap)
      pix_n = '0;
    hs_n = run && (pix_n < HS_W);
`ifdef TV_SYNC_EQ_PULSE_EN
    // two half-width pulses, one per half line
    if (run && eq_line)
      hs_n = (pix_n < EQ_W) ||
             ((pix_n >= half) &&
              (pix_n < half + EQ_W));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix    <= '0;
      hs_out <= 1'b0;
    end else begin
      pix    <= pix_n;
      hs_out <= hs_n;
    end
  end

endmodule

// File: rtl/tv_sync_gen.sv
// tv_sync_gen: interlaced PAL/NTSC HS, VS and field timing source.
// Optional TV_SYNC_EQ_PULSE_EN: equalising pulses on VS lines.
module tv_sync_gen
  import tv_sync_pkg::*;
#(
  parameter int PAL_LINE_CLKS  = PAL_CLKS,
  parameter int NTSC_LINE_CLKS = NTSC_CLKS,
  parameter int PAL_LINES      = PAL_TOTAL,
  parameter int NTSC_LINES     = NTSC_TOTAL,
  parameter int HS_WIDTH       = HS_W_DEF,
  parameter int VS_LINES       = VS_N_DEF
) (
  input  logic       clk_in10M,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       video_mode,
  output logic       hs_out,
  output logic       vs_out,
  output logic       oe_out,
  output logic [9:0] line_num,
  output logic       field_start,
  output logic       frame_start
);

  localparam logic [9:0] P_CLK = 10'(PAL_LINE_CLKS);
  localparam logic [9:0] N_CLK = 10'(NTSC_LINE_CLKS);
  localparam logic [9:0] P_TOT = 10'(PAL_LINES);
  localparam logic [9:0] N_TOT = 10'(NTSC_LINES);
  localparam logic [9:0] P_ODD = 10'(odd_lines(PAL_LINES));
  localparam logic [9:0] N_ODD = 10'(odd_lines(NTSC_LINES));
  localparam logic [9:0] VS_N  = 10'(VS_LINES);

  state_t     state, st_n;
  logic       mode, mode_n;
  logic [9:0] fline, fl_n;
  logic [9:0] ln_n;
  logic       vs_n, oe_n, fs_n, frs_n;
  logic       go, line_wrap;
  logic       wrap_last, wrap_mid;
  logic [9:0] tot, odd_n;
  logic [9:0] cur_clks, nxt_clks;

  assign go        = enable && (state == IDLE);
  assign tot       = (mode == MODE_NTSC) ? N_TOT : P_TOT;
  assign wrap_last = line_wrap && (fline == tot);
  assign wrap_mid  = line_wrap && (fline != tot);
  assign cur_clks  = (mode == MODE_NTSC) ? N_CLK : P_CLK;

  always_comb begin
    st_n   = state;
    mode_n = mode;
    fl_n   = fline;
    unique case (1'b1)
      !enable: begin
        st_n = IDLE;
        fl_n = '0;
      end
      go, wrap_last: begin
        st_n   = ODD;
        mode_n = video_mode;
        fl_n   = 10'd1;
      end
      wrap_mid: begin
        fl_n = fline + 10'd1;
        st_n = (fline >= odd_n) ? EVEN : ODD;
      end
      default: ;
    endcase
  end

  // outputs decoded from next-state values
  always_comb begin
    odd_n    = (mode_n == MODE_NTSC) ? N_ODD : P_ODD;
    nxt_clks = (mode_n == MODE_NTSC) ? N_CLK : P_CLK;
    ln_n     = (st_n == EVEN) ? fl_n - odd_n : fl_n;
    vs_n     = enable && (ln_n <= VS_N);
    oe_n     = (st_n == ODD);
    fs_n     = go || (line_wrap && (ln_n == 10'd1));
    frs_n    = go || wrap_last;
  end

  tv_line_timer #(
    .HS_WIDTH(HS_WIDTH)
  ) u_timer (
    .clk      (clk_in10M),
    .rst_n    (rst_n),
    .run      (enable),
    .start    (state == IDLE),
    .cur_clks (cur_clks),
    .nxt_clks (nxt_clks),
    .eq_line  (vs_n),
    .hs_out   (hs_out),
    .line_wrap(line_wrap)
  );

  always_ff @(posedge clk_in10M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= MODE_PAL;
      fline       <= '0;
      vs_out      <= 1'b0;
      oe_out      <= 1'b0;
      line_num    <= '0;
      field_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= st_n;
      mode        <= mode_n;
      fline       <= fl_n;
      vs_out      <= vs_n;
      oe_out      <= oe_n;
      line_num    <= ln_n;
      field_start <= fs_n;
      frame_start <= frs_n;
    end
  end

endmodule

// File: tb/tb_tv_sync_gen.sv
// tb_tv_sync_gen: directed checks on a full-size and a scaled instance.
// Scaled instance: 64/63 clks per line, 25/21 lines per frame.
module tb_tv_sync_gen;

`ifdef TV_SYNC_EQ_PULSE_EN
  localparam int FULL_HS_L1 = 46;
  localparam int FULL_HS320 = 1;
  localparam int S_PAL_HS   = 119;
  localparam int S_NTSC_HS  = 99;
`else
  localparam int FULL_HS_L1 = 47;
  localparam int FULL_HS320 = 0;
  localparam int S_PAL_HS   = 125;
  localparam int S_NTSC_HS  = 105;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] hs, vs, oe, fs, frs;
  logic [9:0] ln [2];

  int checks = 0;
  int errors = 0;
  int hs_c [2];
  int vs_c [2];
  int oe_c [2];
  int fs_c [2];
  int frs_c [2];
  int max_o [2];
  int max_e [2];

  always #50 clk = ~clk;

  tv_sync_gen dut (
    .clk_in10M  (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .video_mode (mode),
    .hs_out     (hs[0]),
    .vs_out     (vs[0]),
    .oe_out     (oe[0]),
    .line_num   (ln[0]),
    .field_start(fs[0]),
    .frame_start(frs[0])
  );

  tv_sync_gen #(
    .PAL_LINE_CLKS (64),
    .NTSC_LINE_CLKS(63),
    .PAL_LINES     (25),
    .NTSC_LINES    (21),
    .HS_WIDTH      (5),
    .VS_LINES      (3)
  ) dut_s (
    .clk_in10M  (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .video_mode (mode),
    .hs_out     (hs[1]),
    .vs_out     (vs[1]),
    .oe_out     (oe[1]),
    .line_num   (ln[1]),
    .field_start(fs[1]),
    .frame_start(frs[1])
  );

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      hs_c[i] = 0; vs_c[i] = 0; oe_c[i] = 0;
      fs_c[i] = 0; frs_c[i] = 0;
      max_o[i] = 0; max_e[i] = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        hs_c[i]  += int'(hs[i]);
        vs_c[i]  += int'(vs[i]);
        oe_c[i]  += int'(oe[i]);
        fs_c[i]  += int'(fs[i]);
        frs_c[i] += int'(frs[i]);
        if (oe[i]) begin
          if (int'(ln[i]) > max_o[i])
            max_o[i] = int'(ln[i]);
        end else if (int'(ln[i]) > max_e[i]) begin
          max_e[i] = int'(ln[i]);
        end
      end
    end
  endtask

  function automatic int outs(input int i);
    return int'({hs[i], vs[i], oe[i], fs[i],
                 frs[i], ln[i]});
  endfunction

  initial begin
    clr();
    step(2);
    chk("reset_full", outs(0), 0);
    chk("reset_scaled", outs(1), 0);

    rst_n = 1'b1;
    clr();
    step(100);
    chk("idle_hs", hs_c[0] + hs_c[1], 0);
    chk("idle_flags",
        vs_c[0] + oe_c[0] + fs_c[0] + frs_c[0] +
        vs_c[1] + oe_c[1] + fs_c[1] + frs_c[1], 0);
    chk("idle_line", max_e[0] + max_e[1], 0);

    enable = 1'b1;
    clr();
    step(1);
    chk("start_hs", int'(hs[0]), 1);
    chk("start_vs", int'(vs[0]), 1);
    chk("start_oe", int'(oe[0]), 1);
    chk("start_line", int'(ln[0]), 1);
    chk("start_fs", int'(fs[0]), 1);
    chk("start_frs", int'(frs[0]), 1);
    chk("start_s_line", int'(ln[1]), 1);
    step(320);
    chk("pal_hs_pix320", int'(hs[0]), FULL_HS320);
    step(319);
    chk("pal_hs_line1", hs_c[0], FULL_HS_L1);
    chk("pal_fs_line1", fs_c[0], 1);
    step(1);
    chk("pal_l2_line", int'(ln[0]), 2);
    chk("pal_l2_hs", int'(hs[0]), 1);
    chk("pal_l2_vs", int'(vs[0]), 1);
    step(959);
    chk("s_pal_oe", oe_c[1], 832);
    chk("s_pal_hs", hs_c[1], S_PAL_HS);
    chk("s_pal_vs", vs_c[1], 384);
    chk("s_pal_fs", fs_c[1], 2);
    chk("s_pal_frs", frs_c[1], 1);
    chk("s_pal_max_odd", max_o[1], 13);
    chk("s_pal_max_even", max_e[1], 12);

    clr();
    step(1);
    chk("s_frame2_frs", int'(frs[1]), 1);
    chk("s_frame2_oe", int'(oe[1]), 1);
    chk("pal_l3_line", int'(ln[0]), 3);
    mode = 1'b1;
    step(320);
    chk("pal_l4_line", int'(ln[0]), 4);
    chk("pal_l4_vs", int'(vs[0]), 0);
    chk("pal_l4_hs", int'(hs[0]), 1);
    step(1279);
    chk("s_hold_oe", oe_c[1], 832);
    chk("s_hold_hs", hs_c[1], S_PAL_HS);
    chk("s_hold_frs", frs_c[1], 1);

    clr();
    step(1);
    chk("s_ntsc_frs", int'(frs[1]), 1);
    chk("s_ntsc_line", int'(ln[1]), 1);
    chk("pal_hold_line", int'(ln[0]), 6);
    chk("pal_hold_hs", int'(hs[0]), 1);
    step(62);
    chk("s_ntsc_l1_end", int'(ln[1]), 1);
    step(1);
    chk("s_ntsc_l2", int'(ln[1]), 2);
    chk("s_ntsc_l2_hs", int'(hs[1]), 1);
    step(1259);
    chk("s_ntsc_oe", oe_c[1], 693);
    chk("s_ntsc_hs", hs_c[1], S_NTSC_HS);
    chk("s_ntsc_vs", vs_c[1], 378);
    chk("s_ntsc_fs", fs_c[1], 2);
    chk("s_ntsc_frs", frs_c[1], 1);
    chk("s_ntsc_max_odd", max_o[1], 11);
    chk("s_ntsc_max_even", max_e[1], 10);
    step(1);
    chk("s_ntsc_wrap", int'(frs[1]), 1);

    step(703);
    chk("s_even_oe", int'(oe[1]), 0);
    chk("s_even_line", int'(ln[1]), 1);
    chk("s_even_vs", int'(vs[1]), 1);
    enable = 1'b0;
    step(1);
    chk("dis_full", outs(0), 0);
    chk("dis_scaled", outs(1), 0);

    enable = 1'b1;
    clr();
    step(1);
    chk("re_oe", int'(oe[0]), 1);
    chk("re_line", int'(ln[0]), 1);
    chk("re_frs", int'(frs[0]), 1);
    chk("re_fs", int'(fs[0]), 1);
    chk("re_s_oe", int'(oe[1]), 1);
    chk("re_s_frs", int'(frs[1]), 1);
    step(634);
    chk("ntsc_l1_end", int'(ln[0]), 1);
    chk("ntsc_hs_l1", hs_c[0], FULL_HS_L1);
    step(1);
    chk("ntsc_l2", int'(ln[0]), 2);
    chk("ntsc_l2_hs", int'(hs[0]), 1);

    #20;
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_full", outs(0), 0);
    chk("async_rst_scaled", outs(1), 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_idle", outs(0) + outs(1), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
